// File: rtl/branch_sequencer.sv
// Branch resolution controller: drives the 8-bit comparator, computes the relative target,
// inserts the page-cross penalty and hands the redirect to fetch. BRANCH_SEQ_STATS_EN adds counters.
module branch_sequencer #(
    parameter int PENALTY_CYCLES = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        beq_in,
    input  logic        bge_in,
    input  logic        ble_in,
    input  logic [7:0]  opa_in,
    input  logic [7:0]  opb_in,
    input  logic [7:0]  offset_in,
    input  logic [15:0] pc_in,
    output logic        cmp_beq_out,
    output logic        cmp_bge_out,
    output logic        cmp_ble_out,
    output logic [7:0]  cmp_data1_out,
    output logic [7:0]  cmp_data2_out,
    input  logic        cmp_taken_in,
    output logic        redirect_valid_out,
    input  logic        redirect_ready_in,
    output logic [15:0] redirect_pc_out,
    output logic        resolved_out,
    output logic        taken_out,
    output logic        flush_out
`ifdef BRANCH_SEQ_STATS_EN
    ,
    output logic [15:0] branch_cnt_out,
    output logic [15:0] taken_cnt_out
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_PENALTY, S_REDIRECT} state_t;

    localparam logic [1:0] PEN_LOAD = (PENALTY_CYCLES > 0) ? 2'(PENALTY_CYCLES - 1) : 2'd0;

    state_t      state_q, state_d;
    logic [2:0]  cond_q, cond_d;      // {ble, bge, beq}
    logic [7:0]  opa_q, opa_d;
    logic [7:0]  opb_q, opb_d;
    logic [7:0]  off_q, off_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        resolved_q, resolved_d;
    logic        taken_q, taken_d;
    logic        flush_q, flush_d;

    logic [15:0] target;
    logic        page_x;

    assign target = pc_q + {{8{off_q[7]}}, off_q};
    assign page_x = (target[15:8] != pc_q[15:8]);

    always_comb begin
        state_d    = state_q;
        cond_d     = cond_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        off_d      = off_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        resolved_d = 1'b0;
        taken_d    = 1'b0;
        flush_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    cond_d  = {ble_in, bge_in, beq_in};
                    opa_d   = opa_in;
                    opb_d   = opb_in;
                    off_d   = offset_in;
                    pc_d    = pc_in;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (!cmp_taken_in) begin
                    resolved_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (page_x && (PENALTY_CYCLES > 0)) begin
                    cnt_d   = PEN_LOAD;
                    state_d = S_PENALTY;
                end else begin
                    state_d = S_REDIRECT;
                end
            end
            S_PENALTY: begin
                if (cnt_q == 2'd0) state_d = S_REDIRECT;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_REDIRECT: begin
                if (redirect_ready_in) begin
                    resolved_d = 1'b1;
                    taken_d    = 1'b1;
                    flush_d    = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            cond_q     <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            off_q      <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cond_q     <= cond_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            off_q      <= off_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            flush_q    <= flush_d;
        end
    end

    // Outputs are forced low while reset is asserted, before the first reset edge lands.
    assign ready_out          = rst_n_in && (state_q == S_IDLE);
    assign cmp_beq_out        = rst_n_in && (state_q == S_EVAL) && cond_q[0];
    assign cmp_bge_out        = rst_n_in && (state_q == S_EVAL) && cond_q[1];
    assign cmp_ble_out        = rst_n_in && (state_q == S_EVAL) && cond_q[2];
    assign cmp_data1_out      = rst_n_in ? opa_q : 8'd0;
    assign cmp_data2_out      = rst_n_in ? opb_q : 8'd0;
    assign redirect_valid_out = rst_n_in && (state_q == S_REDIRECT);
    assign redirect_pc_out    = rst_n_in ? target : 16'd0;
    assign resolved_out       = rst_n_in && resolved_q;
    assign taken_out          = rst_n_in && taken_q;
    assign flush_out          = rst_n_in && flush_q;

`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0] branch_cnt_q, taken_cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (resolved_q) begin
            if (branch_cnt_q != 16'hFFFF)           branch_cnt_q <= branch_cnt_q + 16'd1;
            if (taken_q && taken_cnt_q != 16'hFFFF) taken_cnt_q  <= taken_cnt_q + 16'd1;
        end
    end

    assign branch_cnt_out = rst_n_in ? branch_cnt_q : 16'd0;
    assign taken_cnt_out  = rst_n_in ? taken_cnt_q  : 16'd0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench: instance A uses PENALTY_CYCLES=1, instance B uses 0, both fed the same stimulus.
module tb_branch_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        valid_in;
    logic        beq_in, bge_in, ble_in;
    logic [7:0]  opa_in, opb_in, offset_in;
    logic [15:0] pc_in;
    logic        redirect_ready_in;

    logic        a_ready, a_beq, a_bge, a_ble, a_taken_cmp, a_rv, a_res, a_tk, a_fl;
    logic [7:0]  a_d1, a_d2;
    logic [15:0] a_pc;
    logic        b_ready, b_beq, b_bge, b_ble, b_taken_cmp, b_rv, b_res, b_tk, b_fl;
    logic [7:0]  b_d1, b_d2;
    logic [15:0] b_pc;
`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0] a_bcnt, a_tcnt, b_bcnt, b_tcnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    // Unsigned 8-bit comparator with OR-combined conditions
    assign a_taken_cmp = (a_beq && a_d1 == a_d2) || (a_bge && a_d1 >= a_d2) || (a_ble && a_d1 <= a_d2);
    assign b_taken_cmp = (b_beq && b_d1 == b_d2) || (b_bge && b_d1 >= b_d2) || (b_ble && b_d1 <= b_d2);

    branch_sequencer #(.PENALTY_CYCLES(1)) dut_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(a_ready),
        .beq_in(beq_in), .bge_in(bge_in), .ble_in(ble_in),
        .opa_in(opa_in), .opb_in(opb_in), .offset_in(offset_in), .pc_in(pc_in),
        .cmp_beq_out(a_beq), .cmp_bge_out(a_bge), .cmp_ble_out(a_ble),
        .cmp_data1_out(a_d1), .cmp_data2_out(a_d2), .cmp_taken_in(a_taken_cmp),
        .redirect_valid_out(a_rv), .redirect_ready_in(redirect_ready_in), .redirect_pc_out(a_pc),
        .resolved_out(a_res), .taken_out(a_tk), .flush_out(a_fl)
`ifdef BRANCH_SEQ_STATS_EN
        , .branch_cnt_out(a_bcnt), .taken_cnt_out(a_tcnt)
`endif
    );

    branch_sequencer #(.PENALTY_CYCLES(0)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(b_ready),
        .beq_in(beq_in), .bge_in(bge_in), .ble_in(ble_in),
        .opa_in(opa_in), .opb_in(opb_in), .offset_in(offset_in), .pc_in(pc_in),
        .cmp_beq_out(b_beq), .cmp_bge_out(b_bge), .cmp_ble_out(b_ble),
        .cmp_data1_out(b_d1), .cmp_data2_out(b_d2), .cmp_taken_in(b_taken_cmp),
        .redirect_valid_out(b_rv), .redirect_ready_in(redirect_ready_in), .redirect_pc_out(b_pc),
        .resolved_out(b_res), .taken_out(b_tk), .flush_out(b_fl)
`ifdef BRANCH_SEQ_STATS_EN
        , .branch_cnt_out(b_bcnt), .taken_cnt_out(b_tcnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Present a branch for one edge; the sequencer must be in IDLE
    task automatic accept(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] off, input logic [15:0] pc);
        {ble_in, bge_in, beq_in} = c;
        opa_in = a; opb_in = b; offset_in = off; pc_in = pc;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0; valid_in = 1'b0;
        {beq_in, bge_in, ble_in} = 3'b000;
        opa_in = '0; opb_in = '0; offset_in = '0; pc_in = '0;
        redirect_ready_in = 1'b0;
        step(); step();
        chk("rst_ready", a_ready, 0);
        chk("rst_rv", a_rv, 0);
        chk("rst_res", a_res, 0);
        chk("rst_tk", a_tk, 0);
        chk("rst_fl", a_fl, 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_d1", a_d1, 0);
        rst_n_in = 1'b1;
        step();
        chk("idle_ready", a_ready, 1);
        chk("idle_ready_b", b_ready, 1);

        // BEQ not taken
        accept(3'b001, 8'h12, 8'h34, 8'h05, 16'h2000);
        chk("beq_strobe", a_beq, 1);
        chk("beq_bge_off", a_bge, 0);
        chk("beq_d1", a_d1, 8'h12);
        chk("beq_d2", a_d2, 8'h34);
        chk("beq_ready_low", a_ready, 0);
        step();
        chk("beq_res", a_res, 1);
        chk("beq_tk", a_tk, 0);
        chk("beq_fl", a_fl, 0);
        chk("beq_rv", a_rv, 0);
        chk("beq_ready", a_ready, 1);
        chk("beq_res_b", b_res, 1);
        step();
        chk("beq_res_drop", a_res, 0);
        chk("beq_strobe_off", a_beq, 0);

        // BGE taken, same page
        redirect_ready_in = 1'b1;
        accept(3'b010, 8'h80, 8'h80, 8'h10, 16'h1234);
        chk("bge_strobe", a_bge, 1);
        step();
        chk("bge_rv", a_rv, 1);
        chk("bge_pc", a_pc, 16'h1244);
        chk("bge_res_early", a_res, 0);
        chk("bge_rv_b", b_rv, 1);
        step();
        chk("bge_fl", a_fl, 1);
        chk("bge_res", a_res, 1);
        chk("bge_tk", a_tk, 1);
        chk("bge_rv_drop", a_rv, 0);
        step();
        chk("bge_fl_drop", a_fl, 0);
        chk("bge_tk_drop", a_tk, 0);

        // BLE taken, backward page cross: A sees one penalty cycle, B none
        accept(3'b100, 8'h05, 8'h09, 8'hF0, 16'h1204);
        chk("ble_strobe", a_ble, 1);
        step();
        chk("ble_pen_rv", a_rv, 0);
        chk("ble_pen_ready", a_ready, 0);
        chk("ble_b_rv", b_rv, 1);
        chk("ble_b_pc", b_pc, 16'h11F4);
        step();
        chk("ble_rv", a_rv, 1);
        chk("ble_pc", a_pc, 16'h11F4);
        chk("ble_b_fl", b_fl, 1);
        step();
        chk("ble_fl", a_fl, 1);
        chk("ble_tk", a_tk, 1);
        chk("ble_b_fl_drop", b_fl, 0);
        step();
        chk("ble_fl_drop", a_fl, 0);

        // Backpressure with address wrap; valid_in pulses must be ignored
        redirect_ready_in = 1'b0;
        accept(3'b001, 8'h07, 8'h07, 8'h20, 16'hFFF0);
        step();
        chk("wrap_b_rv", b_rv, 1);
        chk("wrap_b_pc", b_pc, 16'h0010);
        step();
        for (int i = 0; i < 3; i++) begin
            valid_in = (i != 1);
            opa_in = 8'h01; opb_in = 8'h02; offset_in = 8'h40; pc_in = 16'h5000;
            chk("wrap_rv_hold", a_rv, 1);
            chk("wrap_pc_hold", a_pc, 16'h0010);
            chk("wrap_fl_quiet", a_fl, 0);
            chk("wrap_ready_low", a_ready, 0);
            step();
        end
        valid_in = 1'b0;
        chk("wrap_rv_still", a_rv, 1);
        chk("wrap_d1_hold", a_d1, 8'h07);
        redirect_ready_in = 1'b1;
        step();
        chk("wrap_fl", a_fl, 1);
        chk("wrap_res", a_res, 1);
        chk("wrap_tk", a_tk, 1);
        chk("wrap_b_fl", b_fl, 1);
        step();
        chk("wrap_fl_single", a_fl, 0);
        chk("wrap_ready", a_ready, 1);
        chk("wrap_rv_drop", a_rv, 0);
`ifdef BRANCH_SEQ_STATS_EN
        chk("stats_branch", a_bcnt, 4);
        chk("stats_taken", a_tcnt, 3);
        chk("stats_branch_b", b_bcnt, 4);
`endif

        // Reset while holding a redirect
        redirect_ready_in = 1'b0;
        accept(3'b010, 8'h09, 8'h03, 8'h04, 16'h3000);
        step();
        chk("mid_rv", a_rv, 1);
        chk("mid_pc", a_pc, 16'h3004);
        rst_n_in = 1'b0;
        step();
        chk("mid_rst_rv", a_rv, 0);
        chk("mid_rst_fl", a_fl, 0);
        chk("mid_rst_res", a_res, 0);
        chk("mid_rst_ready", a_ready, 0);
        chk("mid_rst_pc", a_pc, 0);
        chk("mid_rst_d1", a_d1, 0);
        rst_n_in = 1'b1;
        redirect_ready_in = 1'b1;
        step();
        chk("mid_post_ready", a_ready, 1);
        chk("mid_post_fl", a_fl, 0);
        chk("mid_post_res", a_res, 0);
`ifdef BRANCH_SEQ_STATS_EN
        chk("stats_clr_branch", a_bcnt, 0);
        chk("stats_clr_taken", a_tcnt, 0);
`endif
        // Normal branch after the abort: BGE 1>=2 false
        accept(3'b010, 8'h01, 8'h02, 8'h08, 16'h4000);
        step();
        chk("post_res", a_res, 1);
        chk("post_tk", a_tk, 0);
        chk("post_rv", a_rv, 0);
        step();
`ifdef BRANCH_SEQ_STATS_EN
        chk("stats_post_branch", a_bcnt, 1);
        chk("stats_post_taken", a_tcnt, 0);
`endif
        chk("post_ready", a_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
